// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: envelope state encoding and note IDs.
package synth_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  typedef logic [7:0] note_t;

  localparam note_t NOTE_NONE = 8'd0;

endpackage

// File: rtl/env_tick_gen.sv
// Envelope step tick: one-cycle pulse every TICK_DIV clocks, restartable by clear_in.
module env_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic tick_out
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;

  // Next count: wrap at CNT_LAST, restart from zero on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_in) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  // Counter and pre-decoded tick flop, so tick_q is high exactly while cnt_q == CNT_LAST.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope driven by the note decoder's note/gate/trigger interface.
// Define ADSR_EXP_RELEASE_EN for an exponential RELEASE curve instead of linear.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int ENV_WIDTH     = 16,
  parameter int TICK_DIV      = 1000,
  parameter int RELEASE_SHIFT = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           note_in,
  input  logic                 gate_in,
  input  logic                 trigger_in,
  input  logic [ENV_WIDTH-1:0] attack_rate,
  input  logic [ENV_WIDTH-1:0] decay_rate,
  input  logic [ENV_WIDTH-1:0] sustain_level,
  input  logic [ENV_WIDTH-1:0] release_rate,
  output logic [7:0]           note_out,
  output logic [ENV_WIDTH-1:0] env_out,
  output logic                 active_out,
  output logic [2:0]           state_out
);

  localparam logic [ENV_WIDTH-1:0] ENV_MAX  = {ENV_WIDTH{1'b1}};
  localparam logic [ENV_WIDTH-1:0] ENV_ZERO = {ENV_WIDTH{1'b0}};

  env_state_t           state_q, state_d;
  logic [ENV_WIDTH-1:0] env_q, env_d;
  note_t                note_q, note_d;
  logic                 active_q, active_d;

  logic                 trig_ok;
  logic                 tick;
  logic [ENV_WIDTH:0]   attack_sum;
  logic [ENV_WIDTH:0]   decay_diff;
  logic                 decay_hit;
  logic [ENV_WIDTH:0]   rel_diff;
  logic                 rel_hit;

  assign trig_ok = trigger_in && (note_in != NOTE_NONE);

  env_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (trig_ok),
    .tick_out (tick)
  );

  // Extra MSB on each step catches overflow/underflow so the level saturates instead of wrapping.
  assign attack_sum = {1'b0, env_q} + {1'b0, attack_rate};
  assign decay_diff = {1'b0, env_q} - {1'b0, decay_rate};
  assign decay_hit  = (decay_rate == ENV_ZERO) || decay_diff[ENV_WIDTH] ||
                      (decay_diff[ENV_WIDTH-1:0] <= sustain_level);

`ifdef ADSR_EXP_RELEASE_EN
  logic [ENV_WIDTH:0] rel_step;
  assign rel_step = {1'b0, (env_q >> RELEASE_SHIFT)} + (ENV_WIDTH+1)'(1);
  assign rel_diff = {1'b0, env_q} - rel_step;
`else
  localparam int release_shift_unused = RELEASE_SHIFT;
  assign rel_diff = {1'b0, env_q} - {1'b0, release_rate};
`endif
  assign rel_hit = (release_rate == ENV_ZERO) || rel_diff[ENV_WIDTH] ||
                   (rel_diff[ENV_WIDTH-1:0] == ENV_ZERO);

  // Next-state logic; an accepted trigger overrides gate release and any pending step.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    note_d  = note_q;
    if (trig_ok) begin
      state_d = ENV_ATTACK;
      note_d  = note_in;
    end else begin
      case (state_q)
        ENV_IDLE: begin
          env_d = ENV_ZERO;
        end
        ENV_ATTACK: begin
          if (!gate_in) begin
            state_d = ENV_RELEASE;
          end else if (tick) begin
            if ((attack_rate == ENV_ZERO) || attack_sum[ENV_WIDTH] ||
                (attack_sum[ENV_WIDTH-1:0] == ENV_MAX)) begin
              env_d   = ENV_MAX;
              state_d = ENV_DECAY;
            end else begin
              env_d = attack_sum[ENV_WIDTH-1:0];
            end
          end else begin
            env_d = env_q;
          end
        end
        ENV_DECAY: begin
          if (!gate_in) begin
            state_d = ENV_RELEASE;
          end else if (tick) begin
            if (decay_hit) begin
              env_d   = sustain_level;
              state_d = ENV_SUSTAIN;
            end else begin
              env_d = decay_diff[ENV_WIDTH-1:0];
            end
          end else begin
            env_d = env_q;
          end
        end
        ENV_SUSTAIN: begin
          if (!gate_in) begin
            state_d = ENV_RELEASE;
          end else begin
            env_d = sustain_level;
          end
        end
        ENV_RELEASE: begin
          if (tick) begin
            if (rel_hit) begin
              env_d   = ENV_ZERO;
              state_d = ENV_IDLE;
            end else begin
              env_d = rel_diff[ENV_WIDTH-1:0];
            end
          end else begin
            env_d = env_q;
          end
        end
        default: begin
          state_d = ENV_IDLE;
          env_d   = ENV_ZERO;
        end
      endcase
    end
    active_d = (state_d != ENV_IDLE);
  end

  // Output registers; reset aborts the envelope with no fade.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ENV_IDLE;
      env_q    <= ENV_ZERO;
      note_q   <= NOTE_NONE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      note_q   <= note_d;
      active_q <= active_d;
    end
  end

  assign note_out   = note_q;
  assign env_out    = env_q;
  assign active_out = active_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: directed test-plan sequence, then random stimulus.
module tb_adsr_envelope;

  localparam int TD   = 4;
  localparam int EMAX = 65535;
  localparam int RSH  = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  note_in;
  logic        gate_in;
  logic        trigger_in;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] sustain_level;
  logic [15:0] release_rate;
  logic [7:0]  note_out;
  logic [15:0] env_out;
  logic        active_out;
  logic [2:0]  state_out;

  adsr_envelope #(
    .ENV_WIDTH     (16),
    .TICK_DIV      (TD),
    .RELEASE_SHIFT (RSH)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .note_in       (note_in),
    .gate_in       (gate_in),
    .trigger_in    (trigger_in),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .note_out      (note_out),
    .env_out       (env_out),
    .active_out    (active_out),
    .state_out     (state_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int note;
    int env;
    int st;
    int act;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops   = 0;

  // Reference model: st 0..4 = idle/attack/decay/sustain/release; age = cycles since trigger or reset.
  int m_st = 0, m_env = 0, m_note = 0, m_age = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   tick;
    bit   accepted;
    int   ar, dr, sus, rr;
    ar  = attack_rate;
    dr  = decay_rate;
    sus = sustain_level;
    rr  = release_rate;
    if (rst_in) begin
      m_st = 0; m_env = 0; m_note = 0; m_age = 0;
    end else begin
      tick     = ((m_age % TD) == TD - 1);
      accepted = trigger_in && (note_in != 8'd0);
      m_age    = accepted ? 0 : m_age + 1;
      if (accepted) begin
        m_st   = 1;
        m_note = note_in;
      end else begin
        case (m_st)
          0: m_env = 0;
          1: begin
            if (!gate_in) m_st = 4;
            else if (tick) begin
              m_env = (ar == 0) ? EMAX : m_env + ar;
              if (m_env >= EMAX) begin m_env = EMAX; m_st = 2; end
            end
          end
          2: begin
            if (!gate_in) m_st = 4;
            else if (tick) begin
              m_env = (dr == 0) ? sus : m_env - dr;
              if (m_env <= sus) begin m_env = sus; m_st = 3; end
            end
          end
          3: begin
            if (!gate_in) m_st = 4;
            else m_env = sus;
          end
          4: begin
            if (tick) begin
`ifdef ADSR_EXP_RELEASE_EN
              m_env = (rr == 0) ? 0 : m_env - (m_env / (1 << RSH)) - 1;
`else
              m_env = (rr == 0) ? 0 : m_env - rr;
`endif
              if (m_env <= 0) begin m_env = 0; m_st = 0; end
            end
          end
          default: m_st = 0;
        endcase
      end
    end
    e.note = m_note;
    e.env  = m_env;
    e.st   = m_st;
    e.act  = (m_st != 0);
    exp_q.push_back(e);
    pushes++;
  endtask

  // One clock: predict the result of the coming edge, then wait for the next drive point.
  task automatic tc();
    model_step();
    @(negedge clk_in);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tc();
  endtask

  task automatic trig(input int note);
    trigger_in = 1'b1;
    note_in    = 8'(note);
    tc();
    trigger_in = 1'b0;
  endtask

  function automatic logic [15:0] pick_rate();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'($urandom_range(1, 16'h0FFF));
      2:       return 16'($urandom_range(16'h1000, 16'h8000));
      default: return 16'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  // Monitor: outputs are valid every cycle, compared just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pops++;
        check("note_out",   32'(note_out),   32'(e.note));
        check("env_out",    32'(env_out),    32'(e.env));
        check("state_out",  32'(state_out),  32'(e.st));
        check("active_out", 32'(active_out), 32'(e.act));
      end
    end
  end

  initial begin
    int n;
    rst_in = 1'b1; gate_in = 1'b0; trigger_in = 1'b0; note_in = 8'd0;
    attack_rate = 16'h4000; decay_rate = 16'h1000;
    sustain_level = 16'hC000; release_rate = 16'h4000;
    @(negedge clk_in);
    run(2);
    rst_in = 1'b0;
    run(3);

    // Full envelope: attack to max, decay to sustain, live sustain change, release to idle.
    gate_in = 1'b1;
    trig(60);
    run(40);
    sustain_level = 16'hA000;
    run(3);
    gate_in = 1'b0;
    run(16);

    // Retrigger in RELEASE at 0x6000 with a new note.
    gate_in = 1'b1;
    trig(64);
    run(48);
    gate_in = 1'b0;
    n = 0;
    while (m_env != 16'h6000 && n < 20) begin tc(); n++; end
    gate_in = 1'b1;
    trig(64);
    run(8);
    trig(0);
    run(3);

    // Instant attack, then release.
    attack_rate = 16'h0000;
    trig(70);
    run(6);
    gate_in = 1'b0;
    run(24);

    // Reset mid-attack.
    attack_rate = 16'h1000;
    gate_in = 1'b1;
    trig(60);
    run(9);
    rst_in = 1'b1;
    tc();
    rst_in = 1'b0;
    run(3);

    // Trigger together with gate low, then trigger on a tick cycle.
    gate_in = 1'b0;
    trig(5);
    run(6);
    gate_in = 1'b1;
    trig(9);
    run(3);
    trig(11);
    run(10);

    for (int i = 0; i < 3000; i++) begin
      rst_in     = ($urandom_range(0, 499) == 0);
      trigger_in = ($urandom_range(0, 24) == 0);
      note_in    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
      if (trigger_in && $urandom_range(0, 3) != 0) gate_in = 1'b1;
      else if ($urandom_range(0, 29) == 0) gate_in = ~gate_in;
      if ($urandom_range(0, 59) == 0) attack_rate = pick_rate();
      if ($urandom_range(0, 59) == 0) decay_rate = pick_rate();
      if ($urandom_range(0, 59) == 0) release_rate = pick_rate();
      if ($urandom_range(0, 79) == 0) sustain_level = 16'($urandom_range(0, 16'hFFFF));
      tc();
    end
    rst_in = 1'b0;
    trigger_in = 1'b0;

    @(posedge clk_in);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("pop_count", 32'(pops), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
